kosei_gain_ramp: RTL and testbench
==================================

# kosei_gain_ramp

Parametrised, N-channel successor to the stereo volume/soft-mute stage of the DSP path. It accepts one PCM frame (all channels) at a time and applies a Q1.15 gain through a single time-shared multiplier, one channel per cycle. The gain moves toward its target in linear per-frame steps, so volume changes and mute are click-free. It sits after interpolation and ahead of the modulator, with valid/ready on both sides.

## Interface
- `CHANNELS`, default 2: channels per frame (1..16).
- `DATA_W`, default 24: signed sample width.
- `RAMP_STEP`, default 256: gain change per accepted frame, in Q1.15 LSBs (1..32768).
- `clk`, input, 1 bit: the single clock.
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `in_valid`, input, 1 bit: a frame is present.
- `in_ready`, output, 1 bit: the block will accept a frame.
- `in_data`, input, CHANNELS*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W], two's complement.
- `volume_q15`, input, 16 bits: target gain, unsigned Q1.15. Values above 0x8000 are clamped to 0x8000 (unity).
- `soft_mute`, input, 1 bit: when 1, the effective target is 0.
- `out_valid`, output, 1 bit: the output frame is valid.
- `out_ready`, input, 1 bit: downstream accepts the frame.
- `out_data`, output, CHANNELS*DATA_W bits: the gained frame, same packing as `in_data`.
- `mute_done`, output, 1 bit: `soft_mute`=1 and the current gain is 0.

## Operation
- FSM states: IDLE, MUL, HOLD.
  - IDLE → MUL on `in_valid && in_ready`.
  - MUL → HOLD after channel CHANNELS-1.
  - HOLD → IDLE on `out_valid && out_ready`.
- `in_ready` = (state==IDLE) && !`rst`.
- On the accept edge:
  - Latch `in_data` into a frame register.
  - Copy `cur_gain` into `frame_gain`.
  - Set `cur_gain` to `cur_gain` stepped by RAMP_STEP toward the target, with no overshoot. Target = `soft_mute` ? 0 : clamp(`volume_q15`).
- The gain therefore changes only at frame boundaries. All channels of a frame use the same `frame_gain`.
- MUL, per channel c (counter 0..CHANNELS-1):
  - p = sample × {1'b0, `frame_gain`}, signed, DATA_W+17 bits.
  - y = p >>> 15 (arithmetic shift).
  - Write y into slice c of the `out_data` register.
  - Gain ≤ 1.0, so y always fits DATA_W. No saturation logic.
- HOLD: `out_valid`=1. `out_data` is stable until the handshake.
- `mute_done` is a register, updated every cycle as (`soft_mute` && `cur_gain`==0).
- Input changes mid-frame: `volume_q15` and `soft_mute` are sampled only on accept edges. Changes mid-frame affect the next step only.
- Target reversal mid-ramp: the next step moves toward the new target from the current `cur_gain`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `mute_done`=0, `in_ready`=0 while `rst`=1.
  - `cur_gain`=0, so the block starts muted and ramps up.
  - state=IDLE.
- Reset mid-frame: the frame is discarded and `out_valid` drops asynchronously. `in_ready`=1 on the first edge after release.
- Latency: a frame accepted at edge t gives `out_valid`=1 after edge t+CHANNELS.
- Throughput: one frame per CHANNELS+2 cycles with `out_ready` held high. `in_ready` is 0 in MUL and HOLD. No accept occurs in the same cycle as the output handshake.
- `out_ready` low holds HOLD indefinitely. No data is lost or overwritten.
- `mute_done` rises one cycle after the accept edge that makes `cur_gain` 0, with `soft_mute`=1. It falls one cycle after `soft_mute` deasserts.
- Full ramp 0→unity takes ceil(32768/RAMP_STEP) frames. With the default step this is 128.

## Configuration
- `KOSEI_GAIN_ROUND_EN` defined: y = (p + 2^14) >>> 15, i.e. round half up. The result still fits DATA_W because gain ≤ 1.0.
- Undefined: y = p >>> 15, i.e. truncation toward −∞.
- The macro has no other effect on behaviour or timing.

## Test plan
- Reset: `rst`=1 for 5 cycles → all outputs 0 and `in_ready`=0. After release `in_ready`=1. First frame L=0x100000, `volume_q15`=0x8000 → output 0.
- Ramp up, CHANNELS=2, `volume_q15`=0x8000, L=0x100000, R=−0x100000 constant:
  - Frame k (k≥1) output L = 0x100000·min(256k, 32768)/32768.
  - Frame 1 → L=0x2000, R=−0x2000.
  - Frame 129 onward → L=0x100000, R=−0x100000 exactly.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD → `out_valid` held, `out_data` stable, `in_ready`=0. `out_valid` falls on the edge after `out_ready`=1.
- Soft mute from unity: `soft_mute`=1 → 128 frames to gain 0, `mute_done`=1. Later frames output 0. `soft_mute`=0 → `mute_done`=0 and the gain climbs again from 0.
- Rounding: gain 0x4000. Input 3 → 2 with `KOSEI_GAIN_ROUND_EN`, 1 without. Input −3 → −1 with, −2 without. Input −0x800000 at unity → −0x800000 in both builds.
- CHANNELS=4 with `rst` pulsed while MUL is at channel 2 → `out_valid` stays 0 and the frame is dropped. The next frame appears after CHANNELS cycles with gain 0.

Source files
------------

// File: rtl/kosei_gain_ramp.sv
// kosei_gain_ramp: N-channel Q1.15 gain stage, one time-shared multiply per channel per cycle, gain ramps linearly per frame.
// Output valid CHANNELS cycles after accept; one frame in flight, held in HOLD while out_ready is low. KOSEI_GAIN_ROUND_EN selects round-half-up.
module kosei_gain_ramp #(
    parameter int CHANNELS  = 2,
    parameter int DATA_W    = 24,
    parameter int RAMP_STEP = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic [15:0]                volume_q15,
    input  logic                       soft_mute,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    output logic                       mute_done
);

    localparam int          CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int          PW    = DATA_W + 17;
    localparam logic [16:0] STEP  = 17'(RAMP_STEP);
    localparam logic [16:0] UNITY = 17'h08000;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [CHANNELS*DATA_W-1:0] frame_q, frame_d;
    logic [CHANNELS*DATA_W-1:0] out_data_q, out_data_d;
    logic [15:0]                frame_gain_q, frame_gain_d;
    logic [15:0]                cur_gain_q, cur_gain_d;
    logic                       mute_done_q, mute_done_d;

    logic                       accept;
    logic [16:0]                cur_ext;
    logic [16:0]                target;
    logic [16:0]                gain_up;
    logic signed [DATA_W-1:0]   sample;
    logic signed [PW-1:0]       prod;
    logic signed [DATA_W-1:0]   y;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign mute_done = mute_done_q;

    // Target and one-step ramp toward it; never overshoots in either direction.
    always_comb begin
        cur_ext = {1'b0, cur_gain_q};
        target  = '0;
        if (!soft_mute) begin
            target = (volume_q15 > 16'h8000) ? UNITY : {1'b0, volume_q15};
        end
        gain_up = cur_ext + STEP;
    end

    // Time-shared multiplier: channel ch_q of the latched frame times the frame gain.
    always_comb begin
        sample = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CW'(c)) begin
                sample = frame_q[c*DATA_W +: DATA_W];
            end
        end
        prod = PW'(sample) * PW'($signed({1'b0, frame_gain_q}));
`ifdef KOSEI_GAIN_ROUND_EN
        y = DATA_W'((prod + PW'(1 << 14)) >>> 15);
`else
        y = DATA_W'(prod >>> 15);
`endif
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        frame_d      = frame_q;
        frame_gain_d = frame_gain_q;
        cur_gain_d   = cur_gain_q;
        out_data_d   = out_data_q;
        mute_done_d  = soft_mute && (cur_gain_q == 16'h0000);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d      = in_data;
                    frame_gain_d = cur_gain_q;
                    ch_d         = '0;
                    state_d      = MUL;
                    if (cur_ext < target) begin
                        cur_gain_d = (gain_up > target) ? 16'(target) : 16'(gain_up);
                    end else if (cur_ext > target) begin
                        cur_gain_d = (cur_ext < target + STEP) ? 16'(target)
                                                               : 16'(cur_ext - STEP);
                    end
                end
            end
            MUL: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_q == CW'(c)) begin
                        out_data_d[c*DATA_W +: DATA_W] = y;
                    end
                end
                if (ch_q == LAST_CH) begin
                    state_d = HOLD;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            frame_q      <= '0;
            frame_gain_q <= '0;
            cur_gain_q   <= '0;
            out_data_q   <= '0;
            mute_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            frame_q      <= frame_d;
            frame_gain_q <= frame_gain_d;
            cur_gain_q   <= cur_gain_d;
            out_data_q   <= out_data_d;
            mute_done_q  <= mute_done_d;
        end
    end

endmodule

// File: tb/tb_kosei_gain_ramp.sv
// Randomized bench for kosei_gain_ramp against a frame-level gain/ramp reference model.
module tb_kosei_gain_ramp;

    localparam int CH   = 4;
    localparam int DW   = 24;
    localparam int STEP = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH*DW-1:0] in_data;
    logic [15:0]     volume_q15;
    logic            soft_mute;
    logic            out_valid;
    logic            out_ready;
    logic [CH*DW-1:0] out_data;
    logic            mute_done;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     model_gain = 0;
    longint exp_y[CH];

    always #5 clk = ~clk;

    kosei_gain_ramp #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .RAMP_STEP(STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .volume_q15(volume_q15),
        .soft_mute (soft_mute),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mute_done (mute_done)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] sx(input logic [DW-1:0] v);
        return {{(64-DW){v[DW-1]}}, v};
    endfunction

    function automatic longint apply_gain(input logic [DW-1:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
`ifdef KOSEI_GAIN_ROUND_EN
        p = p + 64'sd16384;
`endif
        return p >>> 15;
    endfunction

    function automatic int step_gain(input int g, input int vol, input bit mute);
        int tgt;
        tgt = mute ? 0 : ((vol > 32768) ? 32768 : vol);
        if (g < tgt) return (g + STEP > tgt) ? tgt : g + STEP;
        return (g - STEP < tgt) ? tgt : g - STEP;
    endfunction

    function automatic logic [CH*DW-1:0] mk(input int l, input int r);
        logic [CH*DW-1:0] d;
        for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'($urandom);
        d[0 +: DW]  = DW'(l);
        d[DW +: DW] = DW'(r);
        return d;
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the frame delivered.
    task automatic run_frame(input logic [CH*DW-1:0] dat, input logic [15:0] vol, input bit mute,
                             input int stall, input bit wiggle);
        int n;
        logic [CH*DW-1:0] held;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid   = 1'b1;
        in_data    = dat;
        volume_q15 = vol;
        soft_mute  = mute;
        out_ready  = (stall == 0);
        for (int c = 0; c < CH; c++) exp_y[c] = apply_gain(dat[c*DW +: DW], model_gain);
        model_gain = step_gain(model_gain, int'(vol), mute);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = DW'($urandom);
        if (wiggle) volume_q15 = 16'($urandom);
        for (int i = 0; i < CH; i++) begin
            check("busy_out_valid", out_valid, 0);
            check("busy_in_ready", in_ready, 0);
            @(negedge clk);
        end
        check("out_valid", out_valid, 1);
        for (int c = 0; c < CH; c++) check("out_data", sx(out_data[c*DW +: DW]), exp_y[c]);
        check("mute_done", mute_done, (mute && model_gain == 0));
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_stable", (out_data === held), 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [CH*DW-1:0] d;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        volume_q15 = 16'h0000;
        soft_mute = 1'b0;
        out_ready = 1'b0;
        #1;
        repeat (5) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", (out_data === '0), 1);
            check("rst_mute_done", mute_done, 0);
            check("rst_in_ready", in_ready, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // Starts muted: first frame at gain 0.
        run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, 0, 1'b0);
        check("first_frame_zero", sx(out_data[0 +: DW]), 0);

        // Ramp up to unity.
        for (k = 1; k <= 131; k++) begin
            run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, (k == 3) ? 5 : $urandom_range(0, 2), 1'b0);
            if (k == 1) begin
                check("ramp_k1_L", sx(out_data[0 +: DW]), 64'sh2000);
                check("ramp_k1_R", sx(out_data[DW +: DW]), -64'sh2000);
            end
            if (k >= 129) begin
                check("ramp_unity_L", sx(out_data[0 +: DW]), 64'sh100000);
                check("ramp_unity_R", sx(out_data[DW +: DW]), -64'sh100000);
            end
        end

        // Soft mute from unity.
        for (k = 1; k <= 131; k++) begin
            run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b1, $urandom_range(0, 1), 1'b0);
            if (k >= 129) check("muted_out", sx(out_data[0 +: DW]), 0);
        end
        check("mute_done_set", mute_done, 1);
        run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, 0, 1'b0);
        check("mute_done_clear", mute_done, 0);
        check("unmute_first", sx(out_data[0 +: DW]), 0);
        run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, 0, 1'b0);
        check("unmute_climb", sx(out_data[0 +: DW]), 64'sh2000);

        // Rounding at half gain, then full-scale negative at unity.
        k = 0;
        while (model_gain != 16384 && k < 300) begin
            run_frame(mk($urandom, $urandom), 16'h4000, 1'b0, 0, 1'b0);
            k++;
        end
        run_frame(mk(3, -3), 16'h4000, 1'b0, 0, 1'b0);
`ifdef KOSEI_GAIN_ROUND_EN
        check("round_pos3", sx(out_data[0 +: DW]), 2);
        check("round_neg3", sx(out_data[DW +: DW]), -1);
`else
        check("trunc_pos3", sx(out_data[0 +: DW]), 1);
        check("trunc_neg3", sx(out_data[DW +: DW]), -2);
`endif
        k = 0;
        while (model_gain != 32768 && k < 300) begin
            run_frame(mk($urandom, $urandom), 16'hFFFF, 1'b0, 0, 1'b0);
            k++;
        end
        run_frame(mk(-32'h800000, 32'h7FFFFF), 16'h8000, 1'b0, 0, 1'b0);
        check("unity_min", sx(out_data[0 +: DW]), -64'sh800000);
        check("unity_max", sx(out_data[DW +: DW]), 64'sh7FFFFF);

        // Random volumes, mutes, data and backpressure.
        for (k = 0; k < 200; k++) begin
            for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'($urandom);
            run_frame(d,
                      ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32769, 65535))
                                                  : 16'($urandom_range(0, 32768)),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                      1'b1);
        end

        // Reset while the multiplier is on channel 2.
        in_valid   = 1'b1;
        in_data    = mk(32'h100000, -32'h100000);
        volume_q15 = 16'h8000;
        soft_mute  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_data", (out_data === '0), 1);
        check("mid_rst_mute_done", mute_done, 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_hold_valid", out_valid, 0);
        rst = 1'b0;
        model_gain = 0;
        @(negedge clk);
        check("mid_rst_rel_ready", in_ready, 1);
        check("mid_rst_dropped", out_valid, 0);
        run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, 0, 1'b0);
        check("after_rst_gain0", sx(out_data[0 +: DW]), 0);
        run_frame(mk(32'h100000, -32'h100000), 16'h8000, 1'b0, 0, 1'b0);
        check("after_rst_climb", sx(out_data[0 +: DW]), 64'sh2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
